// File: rtl/sampler.sv
// ---------------------------------------------------------------------------
// sampler
// Programmable-rate input sampler for the logic-analyzer core.
// Captures the probe bus once every (divider+1) clock cycles and presents
// each captured word on smpls_o together with a one-cycle strobe on stb_o.
// The divider is loaded from the command decoder through fdiv_i/set_div_i;
// loading it also restarts the sampling phase.
// All state is reset synchronously by rst_i (active-high).
// ---------------------------------------------------------------------------
module sampler #(
    parameter int WIDTH     = 32,
    parameter int DIV_WIDTH = 24
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [DIV_WIDTH-1:0] fdiv_i,
    input  logic                 set_div_i,
    input  logic [WIDTH-1:0]     data_i,
    output logic [WIDTH-1:0]     smpls_o,
    output logic                 stb_o
);

    // Constant one at counter width, used for the down-count step.
    localparam logic [DIV_WIDTH-1:0] CNT_ONE = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

    // Programmed divider and phase down-counter.
    logic [DIV_WIDTH-1:0] r_div;
    logic [DIV_WIDTH-1:0] r_cnt;

    // Output registers.
    logic [WIDTH-1:0]     r_smpls;
    logic                 r_stb;

    // Next-state values.
    logic [DIV_WIDTH-1:0] w_div_nxt;
    logic [DIV_WIDTH-1:0] w_cnt_nxt;
    logic                 w_cnt_zero;
    logic                 w_take;

    // Decide whether this edge captures a sample: counter expired and no
    // divider load pending (a load always wins and suppresses the sample).
    always_comb begin
        w_cnt_zero = (r_cnt == {DIV_WIDTH{1'b0}});
        if (set_div_i) begin
            w_take = 1'b0;
        end else begin
            w_take = w_cnt_zero;
        end
    end

    // Next divider and counter: load restarts the phase, zero reloads the
    // period, otherwise count down. Reloading at zero means no underflow.
    always_comb begin
        w_div_nxt = r_div;
        w_cnt_nxt = r_cnt;
        if (set_div_i) begin
            w_div_nxt = fdiv_i;
            w_cnt_nxt = fdiv_i;
        end else if (w_cnt_zero) begin
            w_cnt_nxt = r_div;
        end else begin
            w_cnt_nxt = r_cnt - CNT_ONE;
        end
    end

    // Divider and counter registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_div <= {DIV_WIDTH{1'b0}};
            r_cnt <= {DIV_WIDTH{1'b0}};
        end else begin
            r_div <= w_div_nxt;
            r_cnt <= w_cnt_nxt;
        end
    end

    // Output registers: the sample word changes only together with a strobe.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_smpls <= {WIDTH{1'b0}};
            r_stb   <= 1'b0;
        end else begin
            r_stb <= w_take;
            if (w_take) begin
                r_smpls <= data_i;
            end else begin
                r_smpls <= r_smpls;
            end
        end
    end

    assign smpls_o = r_smpls;
    assign stb_o   = r_stb;

endmodule

// File: tb/tb_sampler.sv
// ---------------------------------------------------------------------------
// tb_sampler
// Self-checking bench for sampler. A reference model tracks the absolute edge
// number of the next expected sample and the sampling period; it is advanced
// once per rising edge with the inputs the DUT saw on that edge. Inputs are
// driven 4 ns after each rising edge, outputs are checked 1 ns before the
// next one. A second instance with a 12-bit divider exercises the maximum
// divider value within a short run.
// ---------------------------------------------------------------------------
module tb_sampler;

    logic        clk;
    logic        rst;
    logic [23:0] fdiv;
    logic        set_div;
    logic [31:0] data;
    logic [31:0] smpls;
    logic        stb;

    logic        set2;
    logic [11:0] fdiv2;
    logic [31:0] smpls2;
    logic        stb2;

    int checks;
    int errors;

    // Reference model state
    longint      m_edge;
    longint      m_next;
    longint      m_period;
    logic [31:0] exp_smpl;
    logic        exp_stb;

    sampler dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .fdiv_i   (fdiv),
        .set_div_i(set_div),
        .data_i   (data),
        .smpls_o  (smpls),
        .stb_o    (stb)
    );

    sampler #(.WIDTH(32), .DIV_WIDTH(12)) dut2 (
        .clk_i    (clk),
        .rst_i    (rst),
        .fdiv_i   (fdiv2),
        .set_div_i(set2),
        .data_i   (data),
        .smpls_o  (smpls2),
        .stb_o    (stb2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance the reference model by one rising edge using current inputs.
    task automatic model_edge();
        m_edge = m_edge + 1;
        if (rst) begin
            exp_smpl = 32'h0;
            exp_stb  = 1'b0;
            m_period = 1;
            m_next   = m_edge + 1;
        end else if (set_div) begin
            m_period = longint'(fdiv) + 1;
            m_next   = m_edge + m_period;
            exp_stb  = 1'b0;
        end else if (m_edge == m_next) begin
            exp_smpl = data;
            exp_stb  = 1'b1;
            m_next   = m_edge + m_period;
        end else begin
            exp_stb = 1'b0;
        end
    endtask

    // One clock: edge (model follows), drive inputs for the next edge,
    // then wait until 1 ns before the next edge where outputs are checked.
    task automatic step(input logic r, input logic s, input logic [23:0] f,
                        input logic [31:0] d, input logic s2 = 1'b0);
        @(posedge clk);
        model_edge();
        #4;
        rst     = r;
        set_div = s;
        fdiv    = f;
        data    = d;
        set2    = s2;
        #5;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 24'h0, 32'hFFFF_FFFF);
            checks++;
            if (smpls !== 32'h0 || stb !== 1'b0) begin
                errors++;
                $display("FAIL reset cyc%0d: smpls=%h stb=%b want 0/0", i, smpls, stb);
            end
            checks++;
            if (smpls !== exp_smpl || stb !== exp_stb) begin
                errors++;
                $display("FAIL reset_model: smpls=%h stb=%b want %h/%b", smpls, stb, exp_smpl, exp_stb);
            end
        end
    endtask

    task automatic test_full_rate();
        step(1'b0, 1'b0, 24'h0, 32'h0);       // release reset
        step(1'b0, 1'b1, 24'h0, 32'h0);       // observe E0, drive set N=0
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b0, 24'h0, 32'(i));
            if (i >= 1) begin
                checks++;
                if (stb !== 1'b1 || smpls !== 32'(i - 1)) begin
                    errors++;
                    $display("FAIL full_rate i=%0d: smpls=%h stb=%b want %h/1", i, smpls, stb, 32'(i - 1));
                end
            end
            checks++;
            if (smpls !== exp_smpl || stb !== exp_stb) begin
                errors++;
                $display("FAIL full_rate_model: smpls=%h stb=%b want %h/%b", smpls, stb, exp_smpl, exp_stb);
            end
        end
    endtask

    task automatic test_div4();
        logic [31:0] exp_d;
        logic [31:0] last_cap;
        int          nstb;
        logic        want;
        nstb = 0;
        last_cap = 32'h0;
        step(1'b0, 1'b1, 24'd3, 32'd100);     // set N=3 at edge Es
        step(1'b0, 1'b0, 24'd0, 32'd101);     // observe Es
        checks++;
        if (stb !== 1'b0) begin
            errors++;
            $display("FAIL div4_set_edge: stb=%b want 0", stb);
        end
        for (int k = 1; k <= 20; k++) begin
            exp_d = data;
            step(1'b0, 1'b0, 24'd0, 32'(101 + k));
            want = ((k % 4) == 0);
            checks++;
            if (stb !== want) begin
                errors++;
                $display("FAIL div4_strobe k=%0d: stb=%b want %b", k, stb, want);
            end
            if (want) begin
                checks++;
                if (smpls !== exp_d) begin
                    errors++;
                    $display("FAIL div4_value k=%0d: smpls=%h want %h", k, smpls, exp_d);
                end
                if (nstb > 0) begin
                    checks++;
                    if (smpls - last_cap !== 32'd4) begin
                        errors++;
                        $display("FAIL div4_step: delta=%0d want 4", smpls - last_cap);
                    end
                end
                last_cap = exp_d;
                nstb++;
            end
        end
    endtask

    task automatic test_reprogram();
        int  found;
        logic want;
        found = 0;
        for (int i = 0; i < 8 && found == 0; i++) begin
            step(1'b0, 1'b0, 24'd0, 32'(200 + i));
            if (stb === 1'b1) found = 1;
        end
        checks++;
        if (found == 0) begin
            errors++;
            $display("FAIL reprog_wait: stb=0 want strobe within 8 cycles");
        end
        step(1'b0, 1'b1, 24'd9, 32'd300);     // observe S+1 (cnt=2), set N=9 at S+2
        step(1'b0, 1'b0, 24'd0, 32'd301);     // observe Es = old phase S+2
        checks++;
        if (stb !== 1'b0) begin
            errors++;
            $display("FAIL reprog_set_edge: stb=%b want 0", stb);
        end
        for (int k = 1; k <= 25; k++) begin
            step(1'b0, 1'b0, 24'd0, $urandom);
            want = (k == 10 || k == 20);
            checks++;
            if (stb !== want) begin
                errors++;
                $display("FAIL reprog_strobe k=%0d: stb=%b want %b", k, stb, want);
            end
            checks++;
            if (smpls !== exp_smpl || stb !== exp_stb) begin
                errors++;
                $display("FAIL reprog_model: smpls=%h stb=%b want %h/%b", smpls, stb, exp_smpl, exp_stb);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] exp_d;
        step(1'b0, 1'b1, 24'd5, 32'd7);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 24'd0, $urandom);
        step(1'b1, 1'b0, 24'd0, 32'hDEAD_BEEF); // reset at next edge
        step(1'b0, 1'b0, 24'd0, 32'h0000_1000); // observe reset edge
        checks++;
        if (smpls !== 32'h0 || stb !== 1'b0) begin
            errors++;
            $display("FAIL midrst_clear: smpls=%h stb=%b want 0/0", smpls, stb);
        end
        for (int i = 1; i <= 6; i++) begin
            exp_d = data;
            step(1'b0, 1'b0, 24'd0, 32'h0000_1000 + 32'(i));
            checks++;
            if (stb !== 1'b1 || smpls !== exp_d) begin
                errors++;
                $display("FAIL midrst_full_rate i=%0d: smpls=%h stb=%b want %h/1", i, smpls, stb, exp_d);
            end
        end
    endtask

    task automatic test_random();
        logic        s;
        logic [23:0] f;
        for (int i = 0; i < 300; i++) begin
            s = ($urandom_range(0, 15) == 0);
            f = 24'($urandom_range(0, 7));
            step(1'b0, s, f, $urandom);
            checks++;
            if (smpls !== exp_smpl || stb !== exp_stb) begin
                errors++;
                $display("FAIL random i=%0d: smpls=%h stb=%b want %h/%b", i, smpls, stb, exp_smpl, exp_stb);
            end
        end
    endtask

    task automatic test_max_main();
        int bad;
        bad = 0;
        step(1'b0, 1'b1, 24'hFF_FFFF, 32'h5555_0000);
        for (int i = 0; i < 3000; i++) begin
            step(1'b0, 1'b0, 24'd0, $urandom);
            if (stb !== exp_stb || smpls !== exp_smpl || stb !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL max_main: %0d cycles with strobe or changed sample, want 0", bad);
        end
    endtask

    task automatic test_max_small();
        logic [31:0] hold_exp;
        logic [31:0] exp_d;
        int          strobes;
        int          pos0;
        int          pos1;
        int          unstable;
        strobes = 0; pos0 = -1; pos1 = -1; unstable = 0;
        // dut2 is running at full rate; its last capture is the data now held
        step(1'b0, 1'b0, 24'd0, 32'hA000_0000);
        hold_exp = data;
        step(1'b0, 1'b0, 24'd0, 32'hA000_0001, 1'b1); // set2 at next edge
        for (int k = 0; k <= 8200; k++) begin
            exp_d = data;
            step(1'b0, 1'b0, 24'd0, 32'hA000_0002 + 32'(k));
            if (k == 0) hold_exp = hold_exp;
            if (stb2 === 1'b1) begin
                strobes++;
                if (pos0 < 0) pos0 = k; else if (pos1 < 0) pos1 = k;
                checks++;
                if (smpls2 !== exp_d) begin
                    errors++;
                    $display("FAIL max_value k=%0d: smpls=%h want %h", k, smpls2, exp_d);
                end
                hold_exp = exp_d;
            end else if (smpls2 !== hold_exp) begin
                unstable++;
            end
        end
        checks++;
        if (strobes != 2 || pos0 != 4096 || pos1 != 8192) begin
            errors++;
            $display("FAIL max_period: strobes=%0d at %0d,%0d want 2 at 4096,8192", strobes, pos0, pos1);
        end
        checks++;
        if (unstable != 0) begin
            errors++;
            $display("FAIL max_hold: %0d cycles with changed sample, want 0", unstable);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        m_edge   = 0;
        m_next   = 1;
        m_period = 1;
        exp_smpl = 32'h0;
        exp_stb  = 1'b0;
        rst      = 1'b1;
        set_div  = 1'b0;
        fdiv     = 24'h0;
        data     = 32'hFFFF_FFFF;
        set2     = 1'b0;
        fdiv2    = 12'hFFF;

        test_reset();
        test_full_rate();
        test_div4();
        test_reprogram();
        test_mid_reset();
        test_random();
        test_max_main();
        test_max_small();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sampler.md
# sampler

Programmable-rate input sampler for the logic-analyzer core. It captures the 32-bit probe bus `data_i` once every `fdiv+1` clock cycles and presents each captured word on `smpls_o` with a one-cycle strobe `stb_o`. It sits between the probe inputs and the trigger/memory stages. The divider value is loaded by the command decoder through `fdiv_i` / `set_div_i`.

## Interface
- `WIDTH`, default 32: probe/sample width.
- `DIV_WIDTH`, default 24: divider register width.

Ports:
- `clk_i`  in  1  system clock; all logic is on the rising edge.
- `rst_i`  in  1  synchronous reset, active-high.
- `fdiv_i`  in  DIV_WIDTH  new divider value.
- `set_div_i`  in  1  load strobe for `fdiv_i`; valid for one cycle.
- `data_i`  in  WIDTH  probe bus, already synchronous to `clk_i`.
- `smpls_o`  out  WIDTH  last captured sample, registered.
- `stb_o`  out  1  high for the cycle in which `smpls_o` holds a new sample.

## Operation
- State:
  - `div_q` (DIV_WIDTH): programmed divider.
  - `cnt_q` (DIV_WIDTH): down-counter.
  - Output registers `smpls_o` and `stb_o`.
- Reset (`rst_i`=1 at a rising edge): `div_q`=0, `cnt_q`=0, `smpls_o`=0, `stb_o`=0. Reset overrides every other input.
- Priority per edge (highest first): reset, `set_div_i`, normal counting.
- `set_div_i`=1:
  - `div_q` <= `fdiv_i` and `cnt_q` <= `fdiv_i`, which restarts the phase.
  - `stb_o` <= 0 and `smpls_o` is held. No sample is taken in this cycle.
- Normal counting, when `cnt_q`==0:
  - `smpls_o` <= `data_i`, `stb_o` <= 1, `cnt_q` <= `div_q`.
- Normal counting, otherwise:
  - `cnt_q` <= `cnt_q`-1, `stb_o` <= 0, `smpls_o` is held.
- Sample rate = f_clk/(`div_q`+1).
- `div_q`=0 gives one sample per cycle, with `stb_o` continuously high.
- `div_q`=2^DIV_WIDTH-1 gives the slowest rate, one sample per 2^24 cycles. The counter never underflows because it reloads at zero.
- `smpls_o` changes only together with an `stb_o` assertion (or on reset). Between strobes it holds its value.
- `set_div_i` asserted on consecutive cycles reloads every cycle, so no strobe is emitted until it deasserts.

## Timing
- Capture latency: `data_i` present before rising edge E appears on `smpls_o` after edge E, in the same cycle that `stb_o`=1.
- After reset release (first edge with `rst_i`=0 at E0): `cnt_q`=0, so a sample is taken at E0. `stb_o` is high in the cycle after E0, then every `div_q`+1 edges.
- After `set_div_i`=1 with `fdiv_i`=N at edge Es: the first sample is taken at edge Es+N+1, then at every N+1 edges.
- `stb_o` pulse width is exactly 1 cycle for N≥1.
- Bench drive/sample convention: inputs are driven by the bench mid-cycle (about half a period minus 1 ns after the rising edge), and outputs are sampled just before the rising edge. The design therefore needs no combinational input-to-output path; all outputs are registered.

## Test plan
- Reset: hold `rst_i`=1 for 5 cycles with `data_i`=32'hFFFF_FFFF -> `smpls_o`=0 and `stb_o`=0 throughout.
- Full rate: release reset, set N=0, then drive an incrementing `data_i` 0,1,2,... -> `stb_o` held high, and `smpls_o` follows `data_i` with a 1-cycle delay.
- Divide by 4: set N=3, `data_i` = cycle count -> `stb_o` is high 1 cycle in every 4, the first strobe 4 edges after the set, and captured values step by 4.
- Re-program mid-stream: with N=3 running, set N=9 while `cnt_q`=2 -> no strobe at the old phase, next strobe exactly 10 edges after the set, period 10 thereafter.
- Reset mid-operation: with N=5, assert `rst_i` for 1 cycle -> outputs clear next cycle, `div_q` returns to 0, and sampling then runs at full rate.
- Max divider: set N=24'hFF_FFFF -> exactly one strobe per 16,777,216 cycles (check two consecutive strobes), with `smpls_o` stable in between.
